pn_frame_ctrl: RTL

PN_FRAME_CTRL -- requirements
Module: pn_frame_ctrl

---
 rtl/pn_frame_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pn_frame_ctrl.sv
// pn_frame_ctrl: PN-7 framed bit source with valid/ready handshake.
// Emits bursts of frame_cnt frames of frame_len bits each from a 7-stage PN
// register (c1 <= c7^c4^c3^c2), separating frames by GAP_CYCLES idle
// cycles. frame_cnt = 0 runs until abort.
// Optional feature: define PN_ERR_INJECT_EN to add the err_inject input.
// An err_inject pulse inverts the next accepted bit once.
module pn_frame_ctrl #(
  parameter int GAP_CYCLES = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [6:0]       seed,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       frame_cnt,
  input  logic             bit_ready,
`ifdef PN_ERR_INJECT_EN
  input  logic             err_inject,
`endif
  output logic             bit_out,
  output logic             bit_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frames_sent
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE} state_t;

  // Non-zero fallback for the PN register: used at reset and when seed = 0.
  localparam logic [6:0] PN_DEFAULT = 7'b1000001;

  state_t           state;
  logic [6:0]       pn;          // pn[6] = c7 (output stage), pn[0] = c1
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       cnt_q;
  logic [7:0]       gap_cnt;
  logic             inv;

  logic [6:0]       pn_next;
  logic             accept;
  logic             frame_last;
  logic             last_frame;
  logic             gap_end;

  assign pn_next    = {pn[5:0], pn[6] ^ pn[3] ^ pn[2] ^ pn[1]};
  assign accept     = (state == S_RUN) && bit_ready;
  assign frame_last = (bit_cnt == len_q - LEN_W'(1));
  // Widen to 9 bits so frames_sent = 255 cannot wrap onto a match.
  assign last_frame = (cnt_q != 8'd0) &&
                      (({1'b0, frames_sent} + 9'd1) == {1'b0, cnt_q});
  assign gap_end    = (state == S_GAP) && (gap_cnt == 8'(GAP_CYCLES - 1));
  assign bit_out    = pn[6] ^ inv;

  // Burst FSM with its registered handshake and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pn          <= PN_DEFAULT;
      bit_cnt     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      gap_cnt     <= '0;
      frames_sent <= '0;
      bit_valid   <= 1'b0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      // Abort beats start and every other input. frames_sent is kept.
      state     <= S_IDLE;
      bit_valid <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= only, so every branch sees pre-edge values.
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          pn          <= (seed == 7'd0) ? PN_DEFAULT : seed;
          len_q       <= frame_len;
          cnt_q       <= frame_cnt;
          frames_sent <= '0;
          bit_cnt     <= '0;
          if (frame_len == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state     <= S_RUN;
            bit_valid <= 1'b1;
            sof       <= 1'b1;
            eof       <= (frame_len == LEN_W'(1));
          end
        end
        S_RUN: begin
          if (accept) begin
            pn  <= pn_next;
            sof <= 1'b0;
            if (frame_last) begin
              bit_cnt     <= '0;
              bit_valid   <= 1'b0;
              eof         <= 1'b0;
              frames_sent <= (frames_sent == 8'hFF) ? 8'hFF : frames_sent + 8'd1;
              if (last_frame) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end
            end else begin
              bit_cnt <= bit_cnt + LEN_W'(1);
              eof     <= (bit_cnt + LEN_W'(2) == len_q);
            end
          end
        end
        S_GAP: begin
          if (gap_end) begin
            state     <= S_RUN;
            bit_valid <= 1'b1;
            sof       <= 1'b1;
            eof       <= (len_q == LEN_W'(1));
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PN_ERR_INJECT_EN
  logic armed;
  logic present_new;

  // A new bit appears on bit_out at these edges. The inversion is applied only
  // here, so a bit that is already presented never changes while stalled.
  assign present_new = ((state == S_LOAD) && (frame_len != '0)) ||
                       (accept && !frame_last) || gap_end;

  // Arm on an err_inject pulse. Apply the inversion to the next presented bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed <= 1'b0;
      inv   <= 1'b0;
    end else if (abort) begin
      armed <= 1'b0;
      inv   <= 1'b0;
    end else if (present_new) begin
      inv   <= armed | err_inject;
      armed <= 1'b0;
    end else begin
      if (accept) inv <= 1'b0;
      if (err_inject) armed <= 1'b1;
    end
  end
`else
  assign inv = 1'b0;
`endif

endmodule
